// File: rtl/regfile_pkg.sv
// Shared LEGv8 datapath constants and types used by the register file.
package regfile_pkg;

    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XZR_IDX    = 31;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/regfile.sv
// 32 x 64-bit LEGv8 register file: two combinational read ports, one
// synchronous write port, register XZR hardwired to zero.
module regfile
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = DATA_WIDTH,
    parameter int unsigned NREGS    = NUM_REGS,
    parameter int unsigned ZERO_REG = XZR_IDX
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we3,
    input  logic [$clog2(NREGS)-1:0] ra1,
    input  logic [$clog2(NREGS)-1:0] ra2,
    input  logic [$clog2(NREGS)-1:0] wa3,
    input  logic [WIDTH-1:0]         wd3,
    output logic [WIDTH-1:0]         rd1,
    output logic [WIDTH-1:0]         rd2
);

    localparam int unsigned AW = $clog2(NREGS);

    typedef logic [WIDTH-1:0] bank_t [NREGS-1];

    // Power-up and reset share one image so both give X[i] = i.
    function automatic bank_t reset_image();
        bank_t img;
        for (int unsigned i = 0; i < NREGS - 1; i++) begin
            img[i] = WIDTH'(i);
        end
        return img;
    endfunction

    bank_t regs = reset_image();

    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= reset_image();
        end else if (we3 && (wa3 != AW'(ZERO_REG))) begin
            regs[wa3] <= wd3;
        end
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != AW'(ZERO_REG)) rd1 = regs[ra1];
        if (ra2 != AW'(ZERO_REG)) rd2 = regs[ra2];
    end

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for the LEGv8 register file.
module tb_regfile;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we3 = 1'b0;
    logic [4:0]  ra1 = '0;
    logic [4:0]  ra2 = '0;
    logic [4:0]  wa3 = '0;
    logic [63:0] wd3 = '0;
    logic [63:0] rd1;
    logic [63:0] rd2;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    regfile #(.WIDTH(64), .NREGS(32), .ZERO_REG(31)) dut (
        .clk   (clk),
        .reset (reset),
        .we3   (we3),
        .ra1   (ra1),
        .ra2   (ra2),
        .wa3   (wa3),
        .wd3   (wd3),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and sample 3 ns later.
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    initial begin
        // Power-up contents, before any reset
        ra1 = 5'd7; ra2 = 5'd30;
        #1;
        check("init_rd1_x7", rd1, 64'd7);
        check("init_rd2_x30", rd2, 64'd30);

        // Reset pulse, then sweep
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            ra1 = 5'(2 * i);
            ra2 = 5'(2 * i + 1);
            #1;
            check($sformatf("sweep_rd1_x%0d", 2 * i), rd1, 64'(2 * i));
            check($sformatf("sweep_rd2_x%0d", 2 * i + 1), rd2, 64'(2 * i + 1));
        end
        ra1 = 5'd30;
        #1;
        check("sweep_rd1_x30", rd1, 64'd30);

        // Disabled write
        we3 = 1'b0; wa3 = 5'd0; wd3 = 64'd35; ra1 = 5'd0; ra2 = 5'd1;
        tick();
        check("nowe_rd1_x0", rd1, 64'd0);
        check("nowe_rd2_x1", rd2, 64'd1);
        wa3 = 5'd4; wd3 = 64'd28; ra1 = 5'd4;
        tick();
        check("nowe_rd1_x4", rd1, 64'd4);

        // Enabled write, old value before edge, new after
        we3 = 1'b1; wa3 = 5'd2; wd3 = 64'd27; ra1 = 5'd2; ra2 = 5'd3;
        #1;
        check("wr_before_rd1", rd1, 64'd2);
        tick();
        check("wr_after_rd1", rd1, 64'd27);
        check("wr_after_rd2", rd2, 64'd3);

        // Writes to XZR are ignored
        wa3 = 5'd31; wd3 = 64'd52; ra1 = 5'd30; ra2 = 5'd31;
        tick();
        check("xzr_rd1_x30", rd1, 64'd30);
        check("xzr_rd2_x31", rd2, 64'd0);
        we3 = 1'b0; ra1 = 5'd31;
        tick();
        check("xzr_later_rd1", rd1, 64'd0);

        // Reset wins over a same-edge write; X2 restored
        reset = 1'b1; we3 = 1'b1; wa3 = 5'd5; wd3 = 64'd99; ra1 = 5'd5; ra2 = 5'd2;
        tick();
        reset = 1'b0; we3 = 1'b0;
        #1;
        check("rst_vs_wr_x5", rd1, 64'd5);
        check("rst_restore_x2", rd2, 64'd2);

        // Reset held mid-operation acts only at the edge
        we3 = 1'b1; wa3 = 5'd9; wd3 = 64'h1234; ra1 = 5'd9;
        tick();
        we3 = 1'b0; reset = 1'b1;
        #1;
        check("rst_sync_pre", rd1, 64'h1234);
        tick();
        reset = 1'b0;
        check("rst_sync_post", rd1, 64'd9);

        // Dual-port read of the same freshly written register
        we3 = 1'b1; wa3 = 5'd10; wd3 = 64'hDEADBEEF; ra1 = 5'd10; ra2 = 5'd10;
        tick();
        we3 = 1'b0;
        check("dual_rd1_x10", rd1, 64'hDEADBEEF);
        check("dual_rd2_x10", rd2, 64'hDEADBEEF);

        // Full-width data and a neighbour left untouched
        we3 = 1'b1; wa3 = 5'd30; wd3 = 64'hFFFF_0000_A5A5_5A5A; ra1 = 5'd30; ra2 = 5'd29;
        tick();
        we3 = 1'b0;
        check("wide_rd1_x30", rd1, 64'hFFFF_0000_A5A5_5A5A);
        check("wide_rd2_x29", rd2, 64'd29);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- 32 x 64-bit general-purpose register file for the LEGv8 single-cycle datapath.
- Two combinational read ports and one synchronous write port.
- Register 31 is the hardwired zero register (XZR).
- Sits in the decode stage: it supplies operands to the ALU and takes write-back data from the ALU/memory mux.

Parameters:
- WIDTH, 64, data width of each register and of the rd1/rd2/wd3 ports.
- NREGS, 32, number of architectural registers; address width is log2(NREGS) = 5.
- ZERO_REG, 31, index of the hardwired-zero register.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- we3  input  1  write enable for port 3.
- ra1  input  5  read address, port 1.
- ra2  input  5  read address, port 2.
- wa3  input  5  write address, port 3.
- wd3  input  WIDTH  write data, port 3.
- rd1  output  WIDTH  read data, port 1.
- rd2  output  WIDTH  read data, port 2.
- Positional port order (after clk and reset) is: we3, ra1, ra2, wa3, wd3, rd1, rd2.

Behaviour:
- Storage: registers X0..X30, each WIDTH bits. X31 has no storage and always reads 0.
- Initial contents / reset value: X[i] = i for i = 0..30 (X0=0, X1=1, ..., X30=30).
  - The same values are applied at time 0 (initial load) and on every reset.
- Reset:
  - Sampled on the rising edge of clk while reset = 1; all X0..X30 return to X[i] = i.
  - Reset has priority over a simultaneous write; the write is discarded.
  - Reset asserted mid-operation takes effect at the next rising edge only; no asynchronous action.
- Write:
  - On the rising edge, if reset = 0, we3 = 1 and wa3 != 31, then X[wa3] <= wd3.
  - If we3 = 0, no register changes, regardless of wa3/wd3.
  - Writes to address 31 are silently ignored.
- Read:
  - Purely combinational: rd1 = (ra1 == 31) ? 0 : X[ra1]; rd2 likewise for ra2.
  - Zero latency from address change to data.
- Read during write:
  - No bypass. Before the edge, a read of wa3 returns the old value.
  - After the edge, the read returns wd3 within the same cycle (combinational from the updated array).
- Both read ports may address the same register, or the register being written, simultaneously; each returns an independent correct value.
- Output values are never X/Z after time 0 for any valid address.

Decomposition:
- Shared package (e.g. legv8_pkg): constants DATA_WIDTH = 64, NUM_REGS = 32, REG_ADDR_W = 5, XZR_IDX = 31; typedefs reg_addr_t (logic [4:0]) and word_t (logic [63:0]).
- No sub-module needed: a single module with an array of flops, one write decoder and two read muxes with zero-register masking.

Test Plan:
- Reset / initial state: pulse reset for one edge, then sweep ra1 = 0,2,...,30 and ra2 = 1,3,...,29 with we3 = 0 -> rd1 = ra1 and rd2 = ra2 (e.g. ra1 = 6, ra2 = 7 -> rd1 = 6, rd2 = 7).
- Disabled write: we3 = 0, wa3 = 0, wd3 = 35, ra1 = 0, ra2 = 1 -> after the edge rd1 = 0, rd2 = 1. Repeat with wa3 = 4, wd3 = 28, ra1 = 4 -> rd1 = 4 (unchanged).
- Enabled write: we3 = 1, wa3 = 2, wd3 = 27, ra1 = 2, ra2 = 3 -> before the edge rd1 = 2; 3 ns after the edge rd1 = 27, rd2 = 3.
- Zero register: we3 = 1, wa3 = 31, wd3 = 52, ra1 = 30, ra2 = 31 -> after the edge rd1 = 30, rd2 = 0. Any later read of X31 also gives 0.
- Reset versus write: reset = 1, we3 = 1, wa3 = 5, wd3 = 99 on the same edge -> rd(5) = 5. Also write X2 = 27, then reset -> rd(2) = 2.
- Dual-port same address: write X10 = 0xDEADBEEF, then ra1 = ra2 = 10 -> both outputs = 0xDEADBEEF.
